// File: rtl/polar_pkg.sv
// polar_pkg
//   Shared types and helpers for the polar encode/decode blocks.
//   polar_state_t : framer FSM states (LOAD, ENCODE, HOLD)
//   polar_logn    : log2 of a power-of-two codeword length
package polar_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ENCODE = 2'd1,
        HOLD   = 2'd2
    } polar_state_t;

    function automatic int polar_logn(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// polar_butterfly_stage
//   One combinational XOR butterfly stage of the polar transform.
//   For every index i with (i & span) == 0: dout[i] = din[i] ^ din[i+span];
//   all other positions pass through unchanged.
// Ports
//   din   [0:N-1]     stage input, index 0 = MSB
//   span  [LOGN-1:0]  butterfly distance (a power of two, < N)
//   dout  [0:N-1]     stage output
module polar_butterfly_stage
    import polar_pkg::*;
#(
    parameter int N = 16,
    localparam int LOGN = polar_logn(N)
) (
    input  logic [0:N-1]    din,
    input  logic [LOGN-1:0] span,
    output logic [0:N-1]    dout
);

    logic [0:N-1] sel;

    // With index 0 at the MSB, a left shift by span lines din[i+span] up
    // with position i, so the partner of every upper-half index is one shift away.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            sel[i] = ((i[LOGN-1:0] & span) == '0);
        end
        dout = din ^ ((din << span) & sel);
    end

endmodule

// File: rtl/polar_tx_framer.sv
// polar_tx_framer
//   Sequential polar encoder. Info bits arrive serially and fill the
//   non-frozen positions of u in ascending order (frozen positions forced 0).
//   Then LOGN butterfly stages run one per cycle, and the codeword
//   x = u * F^{(x)n} is held on a valid/ready output until accepted.
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   frozen_bits  [0:N-1] frozen mask, latched at frame start only
//   in_valid / in_ready / in_bit    serial info-bit handshake
//   out_valid / out_ready / out_bits codeword handshake (index 0 = MSB)
//   frame_cnt    [15:0] number of accepted codewords, wrapping
module polar_tx_framer
    import polar_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:N-1] frozen_bits,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:N-1] out_bits,
    output logic [15:0]  frame_cnt
);

    localparam int LOGN = polar_logn(N);
    localparam logic [LOGN:0] N_VEC = (LOGN+1)'(N);

    polar_state_t    state_q, state_d;
    logic [LOGN-1:0] pos_q;
    logic [LOGN-1:0] stage_q;
    logic            primed_q;
    logic [0:N-1]    mask_q;
    logic [0:N-1]    u_q;
    logic [0:N-1]    out_q;
    logic            out_valid_q;
    logic [15:0]     frame_cnt_q;

    logic            load_adv;
    logic            last_pos;
    logic            last_stage;
    logic [LOGN-1:0] span;
    logic [0:N-1]    stage_out;

    // Stage s uses span N >> (s+1): widest butterflies first.
    assign span = LOGN'(N_VEC >> (stage_q + 1'b1));

    polar_butterfly_stage #(.N(N)) u_stage (
        .din  (u_q),
        .span (span),
        .dout (stage_out)
    );

    // primed_q is low only for the first cycle after reset, which is spent
    // latching the frozen mask; later frames latch it on the output handshake.
    assign in_ready   = (state_q == LOAD) && primed_q && !mask_q[pos_q];
    assign load_adv   = (state_q == LOAD) && primed_q && (mask_q[pos_q] || in_valid);
    assign last_pos   = (pos_q == LOGN'(N - 1));
    assign last_stage = (stage_q == LOGN'(LOGN - 1));

    assign out_valid  = out_valid_q;
    assign out_bits   = out_q;
    assign frame_cnt  = frame_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_adv && last_pos) state_d = ENCODE;
            ENCODE:  if (last_stage)           state_d = HOLD;
            HOLD:    if (out_ready)            state_d = LOAD;
            default:                           state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            pos_q       <= '0;
            stage_q     <= '0;
            primed_q    <= 1'b0;
            mask_q      <= '0;
            u_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    if (!primed_q) begin
                        mask_q   <= frozen_bits;
                        primed_q <= 1'b1;
                    end else if (load_adv) begin
                        u_q[pos_q] <= mask_q[pos_q] ? 1'b0 : in_bit;
                        pos_q      <= pos_q + 1'b1;
                        stage_q    <= '0;
                    end
                end
                ENCODE: begin
                    u_q     <= stage_out;
                    stage_q <= stage_q + 1'b1;
                    if (last_stage) begin
                        out_q       <= stage_out;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        pos_q       <= '0;
                        mask_q      <= frozen_bits;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_tx_framer.sv
// tb_polar_tx_framer
//   Directed bench for polar_tx_framer with one N=4 and one N=16 instance.
module tb_polar_tx_framer;

    logic        clk;
    logic        rst4_n, rst16_n;
    logic [0:3]  fb4;
    logic        iv4, ir4, ib4, ov4, ordy4;
    logic [0:3]  ob4;
    logic [15:0] fc4;
    logic [0:15] fb16;
    logic        iv16, ir16, ib16, ov16, ordy16;
    logic [0:15] ob16;
    logic [15:0] fc16;

    int n_cmp;
    int n_bad;

    polar_tx_framer #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .frozen_bits(fb4),
        .in_valid(iv4), .in_ready(ir4), .in_bit(ib4),
        .out_valid(ov4), .out_ready(ordy4), .out_bits(ob4), .frame_cnt(fc4)
    );

    polar_tx_framer #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .frozen_bits(fb16),
        .in_valid(iv16), .in_ready(ir16), .in_bit(ib16),
        .out_valid(ov16), .out_ready(ordy16), .out_bits(ob16), .frame_cnt(fc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: x[j] = XOR of u[i] over all i whose bits cover j.
    function automatic logic [0:15] ref_enc16(input logic [0:15] u);
        logic [0:15] x;
        x = '0;
        for (int j = 0; j < 16; j++)
            for (int i = 0; i < 16; i++)
                if ((i & j) == j) x[j] = x[j] ^ u[i];
        return x;
    endfunction

    function automatic logic [0:15] build_u16(input logic [0:15] mask, input logic [0:15] info);
        logic [0:15] u;
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) u[i] = 1'b0;
            else begin
                u[i] = info[k];
                k++;
            end
        end
        return u;
    endfunction

    task automatic feed4(input logic [0:3] info, output int hs, output int cyc, output logic [7:0] hist);
        int k;
        k = 0; hs = 0; cyc = 0; hist = '0;
        while (!ov4 && cyc < 100) begin
            iv4 = 1'b1;
            ib4 = (k < 4) ? info[k] : 1'b0;
            if (cyc < 8) hist[cyc] = ir4;
            if (ir4) begin hs++; k++; end
            @(negedge clk); cyc++;
        end
        iv4 = 1'b0;
    endtask

    task automatic feed16(input logic [0:15] info, input int gap_mod, input bit scramble,
                          output int hs, output int cyc);
        int k;
        k = 0; hs = 0; cyc = 0;
        while (!ov16 && cyc < 300) begin
            iv16 = (gap_mod == 0) ? 1'b1 : (($urandom % gap_mod) != 0);
            ib16 = (k < 16) ? info[k] : 1'b0;
            if (iv16 && ir16) begin hs++; k++; end
            if (scramble && cyc == 3) fb16 = ~fb16;
            @(negedge clk); cyc++;
        end
        iv16 = 1'b0;
    endtask

    task automatic accept4();
        chk("acc4_valid", 32'(ov4), 32'd1);
        ordy4 = 1'b1;
        @(negedge clk);
        ordy4 = 1'b0;
    endtask

    task automatic accept16();
        chk("acc16_valid", 32'(ov16), 32'd1);
        ordy16 = 1'b1;
        @(negedge clk);
        ordy16 = 1'b0;
    endtask

    initial begin
        int          hs, cyc;
        logic [7:0]  hist;
        logic [0:15] info, cur_mask, next_mask, exp16;

        n_cmp = 0; n_bad = 0;
        rst4_n = 1'b0; rst16_n = 1'b0;
        fb4 = 4'b0000; iv4 = 1'b1; ib4 = 1'b0; ordy4 = 1'b0;
        fb16 = '0; iv16 = 1'b0; ib16 = 1'b0; ordy16 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst4_out_valid", 32'(ov4), 32'd0);
        chk("rst4_in_ready",  32'(ir4), 32'd0);
        chk("rst4_out_bits",  32'(ob4), 32'd0);
        chk("rst4_frame_cnt", 32'(fc4), 32'd0);
        chk("rst16_out_valid", 32'(ov16), 32'd0);
        chk("rst16_frame_cnt", 32'(fc16), 32'd0);

        // Test 1: N=4, no frozen, bits 1,0,0,1 -> 0111, valid 7 cycles after release
        rst4_n = 1'b1;
        feed4(4'b1001, hs, cyc, hist);
        chk("t1_latency",  32'(cyc), 32'd7);
        chk("t1_handshakes", 32'(hs), 32'd4);
        chk("t1_rdy_prime", 32'(hist[0]), 32'd0);
        chk("t1_rdy_pos0",  32'(hist[1]), 32'd1);
        chk("t1_out_bits",  32'(ob4), 32'b0111);
        fb4 = 4'b1000;
        accept4();
        chk("t1_frame_cnt", 32'(fc4), 32'd1);
        chk("t1_valid_drop", 32'(ov4), 32'd0);

        // Test 2: N=4, mask 1000, bits 0,0,1 -> 1111
        feed4(4'b0010, hs, cyc, hist);
        chk("t2_latency",  32'(cyc), 32'd6);
        chk("t2_handshakes", 32'(hs), 32'd3);
        chk("t2_rdy_pos0", 32'(hist[0]), 32'd0);
        chk("t2_rdy_pos1", 32'(hist[1]), 32'd1);
        chk("t2_out_bits", 32'(ob4), 32'b1111);
        accept4();
        chk("t2_frame_cnt", 32'(fc4), 32'd2);

        // Test 4: N=16, no frozen, u[0]=1 -> 1000_0000_0000_0000, then hold
        fb16 = 16'h0000;
        rst16_n = 1'b1;
        feed16(16'h8000, 0, 1'b0, hs, cyc);
        chk("t4_latency",   32'(cyc), 32'd21);
        chk("t4_handshakes", 32'(hs), 32'd16);
        chk("t4_out_bits",  32'(ob16), 32'h8000);
        chk("t4_model",     32'(ob16), 32'(ref_enc16(16'h8000)));
        iv16 = 1'b1; ib16 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_hold_bits",  32'(ob16), 32'h8000);
            chk("t4_hold_valid", 32'(ov16), 32'd1);
            chk("t4_hold_ready", 32'(ir16), 32'd0);
            chk("t4_hold_cnt",   32'(fc16), 32'd0);
        end
        iv16 = 1'b0;
        fb16 = 16'hFFFF;
        accept16();
        chk("t4_frame_cnt", 32'(fc16), 32'd1);
        chk("t4_bits_kept", 32'(ob16), 32'h8000);

        // Test 3: N=16, all frozen -> no handshakes, all-zero codeword after 16+4 cycles
        feed16(16'hFFFF, 0, 1'b0, hs, cyc);
        chk("t3_latency",   32'(cyc), 32'd20);
        chk("t3_handshakes", 32'(hs), 32'd0);
        chk("t3_out_bits",  32'(ob16), 32'h0000);
        next_mask = 16'($urandom);
        fb16 = next_mask;
        accept16();
        chk("t3_frame_cnt", 32'(fc16), 32'd2);

        // Test 5: random masks, input gaps, mid-frame mask changes
        for (int f = 0; f < 4; f++) begin
            cur_mask = next_mask;
            info = 16'($urandom);
            feed16(info, 3, (f % 2) == 0, hs, cyc);
            exp16 = ref_enc16(build_u16(cur_mask, info));
            chk("t5_out_bits",   32'(ob16), 32'(exp16));
            chk("t5_handshakes", 32'(hs), 32'($countones(~cur_mask)));
            next_mask = (f == 3) ? 16'h0F0F : 16'($urandom);
            fb16 = next_mask;
            accept16();
            chk("t5_frame_cnt", 32'(fc16), 32'(3 + f));
        end

        // Test 6: reset after 5 accepted bits discards the frame
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 100) begin
            iv16 = 1'b1; ib16 = 1'b1;
            if (ir16) hs++;
            @(negedge clk); cyc++;
        end
        iv16 = 1'b0;
        chk("t6_partial_hs", 32'(hs), 32'd5);
        rst16_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(ov16), 32'd0);
        chk("t6_rst_cnt",   32'(fc16), 32'd0);
        chk("t6_rst_bits",  32'(ob16), 32'd0);
        chk("t6_rst_ready", 32'(ir16), 32'd0);
        fb16 = 16'h0000;
        rst16_n = 1'b1;
        feed16(16'hA5C3, 0, 1'b0, hs, cyc);
        chk("t6_latency",  32'(cyc), 32'd21);
        chk("t6_out_bits", 32'(ob16), 32'(ref_enc16(16'hA5C3)));
        chk("t6_cnt_pre",  32'(fc16), 32'd0);
        accept16();
        chk("t6_cnt_post", 32'(fc16), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
